// File: rtl/inst_decode_reg.sv
// -----------------------------------------------------------------------------
// inst_decode_reg
//
// Registered, handshaked instruction decoder for the ID stage of the pipelined
// MIPS core. One 32-bit word per cycle is accepted from the IF/ID boundary. It
// is decoded into one-hot class flags, and its register/immediate fields are
// extracted. The result is presented one cycle later as a registered bundle.
// A load-use hazard against the held lw inserts exactly one bubble cycle.
//
// Parameters:
//   DATA_W  - instruction width (decode fields assume 32)
//   EXT_OPS - 1 enables ori/slti/jal; 0 treats those opcodes as illegal
//   CNT_W   - width of the saturating bubble counter
//
// Ports:
//   clk, rst            - rising-edge clock, async active-high reset
//   inst_in, in_valid   - incoming instruction word and its valid
//   in_ready            - word is accepted this cycle (combinational)
//   stall               - downstream busy: hold everything
//   flush               - drop held bundle and current input
//   out_valid           - registered bundle valid
//   rt_type..illegal    - registered one-hot class flags
//   rs, rt, rd, imm     - registered instruction fields
//   hazard              - load-use hazard this cycle (combinational)
//   bubble_cnt          - saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module inst_decode_reg #(
  parameter int DATA_W  = 32,
  parameter int EXT_OPS = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic              rt_type,
  output logic              addi,
  output logic              andi,
  output logic              lw,
  output logic              sw,
  output logic              j,
  output logic              beq,
  output logic              bne,
  output logic              ori,
  output logic              slti,
  output logic              jal,
  output logic              nop,
  output logic              illegal,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic              hazard,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Bit positions of the class flags inside the packed flag vector
  localparam int F_NOP  = 0;
  localparam int F_RT   = 1;
  localparam int F_ADDI = 2;
  localparam int F_ANDI = 3;
  localparam int F_LW   = 4;
  localparam int F_SW   = 5;
  localparam int F_J    = 6;
  localparam int F_BEQ  = 7;
  localparam int F_BNE  = 8;
  localparam int F_ORI  = 9;
  localparam int F_SLTI = 10;
  localparam int F_JAL  = 11;
  localparam int F_ILL  = 12;
  localparam int NFLAGS = 13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Extended opcodes fold into the illegal flag when they are disabled
  localparam int F_ORI_SEL  = (EXT_OPS != 0) ? F_ORI  : F_ILL;
  localparam int F_SLTI_SEL = (EXT_OPS != 0) ? F_SLTI : F_ILL;
  localparam int F_JAL_SEL  = (EXT_OPS != 0) ? F_JAL  : F_ILL;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_outValid;
  logic [NFLAGS-1:0]   r_flags;
  logic [4:0]          r_rs;
  logic [4:0]          r_rt;
  logic [4:0]          r_rd;
  logic [15:0]         r_imm;
  logic [CNT_W-1:0]    r_bubbleCnt;

  logic [5:0]          w_op;
  logic [NFLAGS-1:0]   w_dec;
  logic                w_srcRs;
  logic                w_srcRt;
  logic                w_hazard;
  logic                w_ready;
  logic                w_transfer;

  assign w_op = inst_in[31:26];

  // Opcode decode of the incoming word into a one-hot class vector
  always_comb begin
    w_dec = '0;
    if (inst_in == '0) begin
      w_dec[F_NOP] = 1'b1;
    end else begin
      case (w_op)
        OP_RTYPE: w_dec[F_RT]       = 1'b1;
        OP_ADDI:  w_dec[F_ADDI]     = 1'b1;
        OP_ANDI:  w_dec[F_ANDI]     = 1'b1;
        OP_LW:    w_dec[F_LW]       = 1'b1;
        OP_SW:    w_dec[F_SW]       = 1'b1;
        OP_J:     w_dec[F_J]        = 1'b1;
        OP_BEQ:   w_dec[F_BEQ]      = 1'b1;
        OP_BNE:   w_dec[F_BNE]      = 1'b1;
        OP_ORI:   w_dec[F_ORI_SEL]  = 1'b1;
        OP_SLTI:  w_dec[F_SLTI_SEL] = 1'b1;
        OP_JAL:   w_dec[F_JAL_SEL]  = 1'b1;
        default:  w_dec[F_ILL]      = 1'b1;
      endcase
    end
  end

  // Jumps and nop read no source register; only R-type, sw and branches read rt
  assign w_srcRs = ~(w_dec[F_J] | w_dec[F_JAL] | w_dec[F_NOP]) &
                   (inst_in[25:21] == r_rt);
  assign w_srcRt = (w_dec[F_RT] | w_dec[F_SW] | w_dec[F_BEQ] | w_dec[F_BNE]) &
                   (inst_in[20:16] == r_rt);

  assign w_hazard   = in_valid & r_outValid & r_flags[F_LW] & (r_rt != 5'd0) &
                      (w_srcRs | w_srcRt);
  assign w_ready    = ~rst & ~stall & ~flush & ~w_hazard;
  assign w_transfer = in_valid & w_ready;

  // Pipeline-register FSM: flush beats stall beats hazard beats transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_outValid  <= 1'b0;
      r_flags     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_bubbleCnt <= '0;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_outValid <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        FULL: begin
          if (w_hazard) begin
            r_state    <= BUBBLE;
            r_outValid <= 1'b0;
            if (r_bubbleCnt != '1) begin
              r_bubbleCnt <= r_bubbleCnt + CNT_W'(1);
            end
          end else if (w_transfer) begin
            r_state    <= FULL;
            r_outValid <= 1'b1;
            r_flags    <= w_dec;
            r_rs       <= inst_in[25:21];
            r_rt       <= inst_in[20:16];
            r_rd       <= inst_in[15:11];
            r_imm      <= inst_in[15:0];
          end else begin
            r_state    <= EMPTY;
            r_outValid <= 1'b0;
          end
        end
        default: begin
          // EMPTY and BUBBLE behave alike: the held lw has already left
          if (w_transfer) begin
            r_state    <= FULL;
            r_outValid <= 1'b1;
            r_flags    <= w_dec;
            r_rs       <= inst_in[25:21];
            r_rt       <= inst_in[20:16];
            r_rd       <= inst_in[15:11];
            r_imm      <= inst_in[15:0];
          end else begin
            r_state    <= EMPTY;
            r_outValid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign hazard     = w_hazard;
  assign out_valid  = r_outValid;
  assign nop        = r_flags[F_NOP];
  assign rt_type    = r_flags[F_RT];
  assign addi       = r_flags[F_ADDI];
  assign andi       = r_flags[F_ANDI];
  assign lw         = r_flags[F_LW];
  assign sw         = r_flags[F_SW];
  assign j          = r_flags[F_J];
  assign beq        = r_flags[F_BEQ];
  assign bne        = r_flags[F_BNE];
  assign ori        = r_flags[F_ORI];
  assign slti       = r_flags[F_SLTI];
  assign jal        = r_flags[F_JAL];
  assign illegal    = r_flags[F_ILL];
  assign rs         = r_rs;
  assign rt         = r_rt;
  assign rd         = r_rd;
  assign imm        = r_imm;
  assign bubble_cnt = r_bubbleCnt;

endmodule

// File: tb/tb_inst_decode_reg.sv
// -----------------------------------------------------------------------------
// tb_inst_decode_reg
//
// Drives two decoders from the same stimulus: one with the base opcode set and
// an 8-bit bubble counter, one with the extended opcodes and a 2-bit counter.
// A reference model tracks only "which word is held and is it valid" plus the
// bubble count, and derives the expected bundle from the opcode table.
// -----------------------------------------------------------------------------
module tb_inst_decode_reg;

  logic        clk;
  logic        rst;
  logic [31:0] instIn;
  logic        inValid;
  logic        stall;
  logic        flush;

  // DUT A: EXT_OPS=0, CNT_W=8
  logic aInReady, aOutValid, aHazard;
  logic aRtType, aAddi, aAndi, aLw, aSw, aJ, aBeq, aBne, aOri, aSlti, aJal, aNop, aIllegal;
  logic [4:0]  aRs, aRt, aRd;
  logic [15:0] aImm;
  logic [7:0]  aCnt;

  // DUT B: EXT_OPS=1, CNT_W=2
  logic bInReady, bOutValid, bHazard;
  logic bRtType, bAddi, bAndi, bLw, bSw, bJ, bBeq, bBne, bOri, bSlti, bJal, bNop, bIllegal;
  logic [4:0]  bRs, bRt, bRd;
  logic [15:0] bImm;
  logic [1:0]  bCnt;

  inst_decode_reg #(.DATA_W(32), .EXT_OPS(0), .CNT_W(8)) dutA (
    .clk(clk), .rst(rst), .inst_in(instIn), .in_valid(inValid), .in_ready(aInReady),
    .stall(stall), .flush(flush), .out_valid(aOutValid),
    .rt_type(aRtType), .addi(aAddi), .andi(aAndi), .lw(aLw), .sw(aSw), .j(aJ),
    .beq(aBeq), .bne(aBne), .ori(aOri), .slti(aSlti), .jal(aJal), .nop(aNop),
    .illegal(aIllegal), .rs(aRs), .rt(aRt), .rd(aRd), .imm(aImm),
    .hazard(aHazard), .bubble_cnt(aCnt)
  );

  inst_decode_reg #(.DATA_W(32), .EXT_OPS(1), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .inst_in(instIn), .in_valid(inValid), .in_ready(bInReady),
    .stall(stall), .flush(flush), .out_valid(bOutValid),
    .rt_type(bRtType), .addi(bAddi), .andi(bAndi), .lw(bLw), .sw(bSw), .j(bJ),
    .beq(bBeq), .bne(bBne), .ori(bOri), .slti(bSlti), .jal(bJal), .nop(bNop),
    .illegal(bIllegal), .rs(bRs), .rt(bRt), .rd(bRd), .imm(bImm),
    .hazard(bHazard), .bubble_cnt(bCnt)
  );

  // Flag vectors with bit position == class code used by the model
  logic [12:0] flagsOut [2];
  logic        validOut [2];
  logic        readyOut [2];
  logic        hazOut   [2];
  logic [4:0]  rsOut    [2];
  logic [4:0]  rtOut    [2];
  logic [4:0]  rdOut    [2];
  logic [15:0] immOut   [2];
  logic [7:0]  cntOut   [2];

  assign flagsOut[0] = {aIllegal, aJal, aSlti, aOri, aBne, aBeq, aJ, aSw, aLw, aAndi, aAddi, aRtType, aNop};
  assign flagsOut[1] = {bIllegal, bJal, bSlti, bOri, bBne, bBeq, bJ, bSw, bLw, bAndi, bAddi, bRtType, bNop};
  assign validOut[0] = aOutValid;
  assign validOut[1] = bOutValid;
  assign readyOut[0] = aInReady;
  assign readyOut[1] = bInReady;
  assign hazOut[0]   = aHazard;
  assign hazOut[1]   = bHazard;
  assign rsOut[0]    = aRs;
  assign rsOut[1]    = bRs;
  assign rtOut[0]    = aRt;
  assign rtOut[1]    = bRt;
  assign rdOut[0]    = aRd;
  assign rdOut[1]    = bRd;
  assign immOut[0]   = aImm;
  assign immOut[1]   = bImm;
  assign cntOut[0]   = aCnt;
  assign cntOut[1]   = {6'd0, bCnt};

  // Reference model state per configuration
  int          extCfg [2] = '{0, 1};
  int          cntMax [2] = '{255, 3};
  logic        mValid [2];
  logic [31:0] mWord  [2];
  int          mCnt   [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Class codes: 0 nop, 1 R-type, 2 addi, 3 andi, 4 lw, 5 sw, 6 j, 7 beq,
  // 8 bne, 9 ori, 10 slti, 11 jal, 12 illegal
  function automatic int classOf(input logic [31:0] w, input int ext);
    if (w == 32'd0) return 0;
    case (int'(w[31:26]))
      0:  return 1;
      8:  return 2;
      12: return 3;
      35: return 4;
      43: return 5;
      2:  return 6;
      4:  return 7;
      5:  return 8;
      13: return (ext != 0) ? 9  : 12;
      10: return (ext != 0) ? 10 : 12;
      3:  return (ext != 0) ? 11 : 12;
      default: return 12;
    endcase
  endfunction

  function automatic logic hazOf(input int k);
    logic [4:0] heldRt;
    int         c;
    logic       useRs, useRt;
    heldRt = mWord[k][20:16];
    c      = classOf(instIn, extCfg[k]);
    useRs  = !(c == 0 || c == 6 || c == 11);
    useRt  = (c == 1 || c == 5 || c == 7 || c == 8);
    return inValid && mValid[k] && classOf(mWord[k], extCfg[k]) == 4 && heldRt != 5'd0 &&
           ((useRs && instIn[25:21] == heldRt) || (useRt && instIn[20:16] == heldRt));
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] observed=0x%0h expected=0x%0h t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  // Registered bundle versus the model, sampled 1 time unit after the edge
  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      check("out_valid", k, 32'(validOut[k]), 32'(mValid[k]));
      if (mValid[k]) begin
        check("flags", k, 32'(flagsOut[k]), 32'(1) << classOf(mWord[k], extCfg[k]));
        check("rs",    k, 32'(rsOut[k]),  32'(mWord[k][25:21]));
        check("rt",    k, 32'(rtOut[k]),  32'(mWord[k][20:16]));
        check("rd",    k, 32'(rdOut[k]),  32'(mWord[k][15:11]));
        check("imm",   k, 32'(immOut[k]), 32'(mWord[k][15:0]));
      end
      check("bubble_cnt", k, 32'(cntOut[k]), 32'(mCnt[k]));
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance model
  task automatic applyStimulus(input logic [31:0] word, input logic v, input logic s, input logic f);
    logic eh [2];
    logic er [2];
    @(negedge clk);
    instIn  = word;
    inValid = v;
    stall   = s;
    flush   = f;
    #1;
    for (int k = 0; k < 2; k++) begin
      eh[k] = hazOf(k);
      er[k] = !rst && !s && !f && !eh[k];
      check("hazard",   k, 32'(hazOut[k]),   32'(eh[k]));
      check("in_ready", k, 32'(readyOut[k]), 32'(er[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (f) begin
        mValid[k] = 1'b0;
      end else if (s) begin
        // hold
      end else if (eh[k]) begin
        mValid[k] = 1'b0;
        if (mCnt[k] < cntMax[k]) mCnt[k]++;
      end else if (v && er[k]) begin
        mValid[k] = 1'b1;
        mWord[k]  = word;
      end else begin
        mValid[k] = 1'b0;
      end
    end
    #1;
    checkOutput();
  endtask

  // Async reset a couple of units into the low phase; outputs clear at once
  task automatic applyReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      mValid[k] = 1'b0;
      mCnt[k]   = 0;
      check("rst_out_valid", k, 32'(validOut[k]), 32'd0);
      check("rst_flags",     k, 32'(flagsOut[k]), 32'd0);
      check("rst_fields",    k, {rsOut[k], rtOut[k], rdOut[k], 17'd0}, 32'd0);
      check("rst_imm",       k, 32'(immOut[k]),   32'd0);
      check("rst_cnt",       k, 32'(cntOut[k]),   32'd0);
      check("rst_in_ready",  k, 32'(readyOut[k]), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] randWord();
    logic [5:0] ops [13] = '{6'd0, 6'd8, 6'd12, 6'd35, 6'd43, 6'd2, 6'd4, 6'd5,
                             6'd13, 6'd10, 6'd3, 6'd63, 6'd35};
    logic [31:0] w;
    if ($urandom_range(0, 15) == 0) return 32'd0;
    w = {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
         16'($urandom)};
    return w;
  endfunction

  initial begin
    rst     = 1'b1;
    instIn  = 32'd0;
    inValid = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mValid[k] = 1'b0;
      mWord[k]  = 32'd0;
      mCnt[k]   = 0;
    end
    $display("[TB] start");
    applyReset();

    $display("[TB] addi / nop / add stream");
    applyStimulus(32'h20080005, 1, 0, 0);
    applyStimulus(32'h00000000, 1, 0, 0);
    applyStimulus(32'h012A4020, 1, 0, 0);
    applyStimulus(32'h00000000, 0, 0, 0);

    $display("[TB] load-use hazard");
    applyStimulus(32'h8C090000, 1, 0, 0);
    applyStimulus(32'h01294020, 1, 0, 0);
    applyStimulus(32'h01294020, 1, 0, 0);
    applyStimulus(32'h00000000, 0, 0, 0);

    $display("[TB] lw to $0 causes no bubble");
    applyStimulus(32'h8C000000, 1, 0, 0);
    applyStimulus(32'h00004020, 1, 0, 0);

    $display("[TB] jal, ori, slti per config");
    applyStimulus(32'h0C000010, 1, 0, 0);
    applyStimulus(32'h3508FFFF, 1, 0, 0);
    applyStimulus(32'h2909000A, 1, 0, 0);
    applyStimulus(32'hFC000000, 1, 0, 0);

    $display("[TB] stall while holding beq");
    applyStimulus(32'h11090004, 1, 0, 0);
    applyStimulus(32'h20080005, 1, 1, 0);
    applyStimulus(32'h20080005, 1, 1, 0);
    applyStimulus(32'h20080005, 1, 1, 0);
    applyStimulus(32'h20080005, 1, 0, 0);

    $display("[TB] flush with stall while full");
    applyStimulus(32'h3108000F, 1, 1, 1);
    applyStimulus(32'h00000000, 0, 0, 0);

    $display("[TB] hazard together with stall");
    applyStimulus(32'h8C090000, 1, 0, 0);
    applyStimulus(32'hAD290004, 1, 1, 0);
    applyStimulus(32'hAD290004, 1, 0, 0);
    applyStimulus(32'hAD290004, 1, 0, 0);

    $display("[TB] reset mid-stream");
    applyStimulus(32'h8C0A0000, 1, 0, 0);
    applyReset();

    $display("[TB] five load-use pairs");
    for (int p = 0; p < 5; p++) begin
      applyStimulus(32'h8C090000, 1, 0, 0);
      applyStimulus(32'h01294020, 1, 0, 0);
      applyStimulus(32'h01294020, 1, 0, 0);
    end

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(randWord(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_decode_reg.md
# inst_decode_reg

Registered, handshaked instruction decoder for the ID stage of the pipelined MIPS core. It accepts one 32-bit instruction per cycle from the IF/ID boundary and decodes the opcode into one-hot class flags. It extracts the register and immediate fields, detects load-use hazards against the instruction it currently holds, and presents everything one cycle later as a registered ID/EX-side bundle. A parameter enables an extended opcode set.

## Interface
- `DATA_W`, 32: instruction width; fixed decode fields assume 32.
- `EXT_OPS`, 0: 1 enables decode of `ori`, `slti` and `jal`; 0 forces those flags to 0 and classifies those opcodes as illegal.
- `CNT_W`, 8: width of the saturating bubble counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_in` in DATA_W: instruction word.
- `in_valid` in 1: `inst_in` is valid.
- `in_ready` out 1: decoder accepts `inst_in` this cycle (combinational).
- `stall` in 1: downstream cannot take the output; hold.
- `flush` in 1: discard the held output and the current input.
- `out_valid` out 1: the registered bundle is valid.
- `rt_type`, `addi`, `andi`, `lw`, `sw`, `j`, `beq`, `bne`, `ori`, `slti`, `jal`, `nop`, `illegal` out 1 each: registered one-hot class flags.
- `rs`, `rt`, `rd` out 5 each: registered fields `inst[25:21]`, `inst[20:16]` and `inst[15:11]`.
- `imm` out 16: registered `inst[15:0]`.
- `hazard` out 1: load-use hazard detected this cycle (combinational).
- `bubble_cnt` out CNT_W: count of inserted bubbles; saturates at all-ones.

## Operation
- Decode of an accepted word:
  - `nop`=1 iff the word is all zero.
  - `rt_type`=1 iff opcode is 000000 and the word is non-zero.
  - 001000 → `addi`; 001100 → `andi`; 100011 → `lw`; 101011 → `sw`; 000010 → `j`; 000100 → `beq`; 000101 → `bne`.
  - With `EXT_OPS`=1: 001101 → `ori`; 001010 → `slti`; 000011 → `jal`.
  - Any other opcode sets `illegal`=1. Exactly one flag is 1 whenever `out_valid`=1.
- Hazard detection (combinational):
  - `hazard` = `in_valid` & `out_valid` & `lw`(held) & (held `rt`≠0) & (src_rs | src_rt).
  - src_rs = `inst_in[25:21]` equals held `rt`, evaluated for every class except `j`, `jal` and `nop`.
  - src_rt = `inst_in[20:16]` equals held `rt`, evaluated only for R-type, `sw`, `beq` and `bne`.
- Handshake: `in_ready` = ~`rst` & ~`stall` & ~`flush` & ~`hazard`. A transfer occurs when `in_valid` & `in_ready`.
- State machine:
  - EMPTY (`out_valid`=0). A transfer goes to FULL.
  - FULL (`out_valid`=1). A transfer stays in FULL with a new bundle. `in_valid`=0 with no stall goes to EMPTY. `stall` holds FULL.
  - BUBBLE (`out_valid`=0, entered from FULL on `hazard` & ~`stall` & ~`flush`). `bubble_cnt` increments on entry. The next cycle behaves as EMPTY; the held `lw` has left, so the stalled word is accepted.
- Priority per cycle: `flush` > `stall` > `hazard` > transfer.
  - `flush`: next state EMPTY, `out_valid` 0; input dropped, no count.
  - `stall`: all registers hold, including `out_valid`.
- Field and flag registers update only on a transfer; at other times their contents are don't-care while `out_valid`=0.

## Timing
- Latency: 1 cycle from transfer to `out_valid`=1 with the decoded bundle.
- Throughput: 1 instruction per cycle; each load-use hazard costs exactly 1 bubble cycle.
- Reset state (async, immediate): `out_valid`=0, all flags 0, `rs`/`rt`/`rd`=0, `imm`=0, `bubble_cnt`=0, state EMPTY. `in_ready`=0 while `rst` is high.
- Reset mid-stream drops the held instruction. The first transfer is possible in the first cycle after deassertion.
- `bubble_cnt` at 2^CNT_W−1 stays there.
- `hazard` with `stall` together: no bubble, no count; the hazard is re-evaluated next cycle.

## Test plan
- Reset, then stream `0x20080005` (addi), `0x00000000`, `0x012A4020` (add) with `in_valid`=1 → one cycle later `addi`=1/`rt`=8/`imm`=5, then `nop`=1, then `rt_type`=1/`rd`=8; `out_valid` continuous.
- `0x8C090000` (lw $9) followed by `0x01294020` (add $8,$9,$9) → `hazard`=1 and `in_ready`=0 for 1 cycle, one `out_valid`=0 cycle, add appears next, `bubble_cnt`=1. With lw rt=0 instead → no bubble.
- `EXT_OPS`=0 versus 1 with `0x0C000010` (jal) → `illegal`=1 versus `jal`=1.
- `stall`=1 for 3 cycles while holding `beq` → outputs unchanged and `in_ready`=0; resumes with the next word on release.
- `flush` and `stall` together while FULL → `out_valid`=0 next cycle, input not consumed; async `rst` mid-stream → all outputs 0 immediately.
- `CNT_W`=2 with 5 load-use pairs → `bubble_cnt` reads 1, 2, 3, 3, 3.
